// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Optional range checking of word indices is enabled by DMEM_ARB_BOUNDS_CHECK_EN.
module dmem_arbiter #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_rvalid,
  output logic        p1_rvalid,
  output logic [31:0] p0_rdata,
  output logic [31:0] p1_rdata,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_nx;
  logic        last_win;
  logic        win;
  logic        sel_q, we_q, oob_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] sel_addr;
  logic [31:0] rd_word;
  logic        oob_nx;
  logic        err_q;
  logic        in_acc;

  // On a tie the port that was not served last wins
  assign win = (p0_req & p1_req) ? ~last_win : p1_req;
  assign sel_addr = win ? p1_addr : p0_addr;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  logic [7:0] idx;
  assign idx    = sel_addr[9:2];
  assign oob_nx = {24'd0, idx} >= 32'(MEM_WORDS);
`else
  assign oob_nx = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    p0_gnt   = 1'b0;
    p1_gnt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (p0_req | p1_req) begin
          state_nx = ACCESS;
          p0_gnt   = rst_n & ~win;
          p1_gnt   = rst_n & win;
        end
      end
      ACCESS: state_nx = IDLE;
    endcase
  end

  assign in_acc    = (state == ACCESS);
  assign mem_write = in_acc & we_q & ~oob_q;
  assign mem_read  = in_acc & ~we_q & ~oob_q;
  assign mem_addr  = in_acc ? addr_q : 32'd0;
  assign mem_wdata = in_acc ? wdata_q : 32'd0;
  assign rd_word   = oob_q ? 32'd0 : mem_rdata;
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_win  <= 1'b1;
      sel_q     <= 1'b0;
      we_q      <= 1'b0;
      oob_q     <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= 32'd0;
      p1_rdata  <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      err_q     <= 1'b0;
      if (p0_gnt | p1_gnt) begin
        last_win <= win;
        sel_q    <= win;
        we_q     <= win ? p1_we : p0_we;
        addr_q   <= sel_addr;
        wdata_q  <= win ? p1_wdata : p0_wdata;
        oob_q    <= oob_nx;
      end
      if (in_acc) begin
        err_q <= oob_q;
        if (!we_q) begin
          if (sel_q) begin
            p1_rvalid <= 1'b1;
            p1_rdata  <= rd_word;
          end else begin
            p0_rvalid <= 1'b1;
            p0_rdata  <= rd_word;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: cycle tables plus reset and range cases.
// Build with or without DMEM_ARB_BOUNDS_CHECK_EN to match the RTL.
module tb_dmem_arbiter;

  logic        clk, rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_write, mem_read, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [256];

  int n_chk;
  int n_fail;

  dmem_arbiter #(.MEM_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk)
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  typedef struct {
    logic        rst;
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        g0, g1, v0, v1;
    logic [31:0] q0, q1;
    logic        mw, mr;
    logic [31:0] ma, md;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " gnt0"}, 32'(p0_gnt), 0);
    chk({tag, " gnt1"}, 32'(p1_gnt), 0);
    chk({tag, " rv0"}, 32'(p0_rvalid), 0);
    chk({tag, " rv1"}, 32'(p1_rvalid), 0);
    chk({tag, " rd0"}, p0_rdata, 0);
    chk({tag, " rd1"}, p1_rdata, 0);
    chk({tag, " mw"}, 32'(mem_write), 0);
    chk({tag, " mr"}, 32'(mem_read), 0);
    chk({tag, " ma"}, mem_addr, 0);
    chk({tag, " md"}, mem_wdata, 0);
    chk({tag, " err"}, 32'(err), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_in();
    rst_n = 0;
    #1 chk_zero("rst");
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic run_row(input int i, input vec_t t);
    string s;
    if (t.rst) do_reset();
    @(negedge clk);
    p0_req = t.r0; p0_we = t.w0; p0_addr = t.a0; p0_wdata = t.d0;
    p1_req = t.r1; p1_we = t.w1; p1_addr = t.a1; p1_wdata = t.d1;
    #1;
    s = $sformatf("row%0d", i);
    chk({s, " gnt0"}, 32'(p0_gnt), 32'(t.g0));
    chk({s, " gnt1"}, 32'(p1_gnt), 32'(t.g1));
    chk({s, " rv0"}, 32'(p0_rvalid), 32'(t.v0));
    chk({s, " rv1"}, 32'(p1_rvalid), 32'(t.v1));
    chk({s, " rd0"}, p0_rdata, t.q0);
    chk({s, " rd1"}, p1_rdata, t.q1);
    chk({s, " mw"}, 32'(mem_write), 32'(t.mw));
    chk({s, " mr"}, 32'(mem_read), 32'(t.mr));
    chk({s, " ma"}, mem_addr, t.ma);
    chk({s, " md"}, mem_wdata, t.md);
    chk({s, " err"}, 32'(err), 0);
  endtask

  task automatic p0_read(input logic [31:0] a);
    @(negedge clk);
    p0_req = 1; p0_we = 0; p0_addr = a; p0_wdata = 0;
    #1 chk("rd gnt0", 32'(p0_gnt), 1);
    @(negedge clk);
    p0_req = 0;
  endtask

  localparam logic [31:0] A0 = 32'hA0A0A0A0;
  localparam logic [31:0] B1 = 32'hB1B1B1B1;
  localparam logic [31:0] DB = 32'hDEADBEEF;

  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
    mem[16] <= A0;
    mem[17] <= B1;
    mem[8]  <= 32'h55555555;
    mem[63] <= 32'h63636363;
    mem[64] <= 32'h77777777;
    idle_in();
    rst_n = 1;
    #1 rst_n = 0;
    #1 chk_zero("por");
    @(negedge clk);
    rst_n = 1;

    // write then read back on p0
    tbl.push_back(vec_t'{0, 1,1,'h10,DB, 0,0,0,0, 1,0,0,0, 0,0, 0,0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0, 1,0,'h10,DB});
    tbl.push_back(vec_t'{0, 1,0,'h10,0, 0,0,0,0, 1,0,0,0, 0,0, 0,0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0, 0,1,'h10,0});
    tbl.push_back(vec_t'{0, 0,0,0,0, 0,0,0,0, 0,0,1,0, DB,0, 0,0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,0, 0,0,0,0, 0,0,0,0, DB,0, 0,0,0,0});
    // both ports reading after reset: p0, p1, p0
    tbl.push_back(vec_t'{1, 1,0,'h40,0, 1,0,'h44,0, 1,0,0,0, 0,0, 0,0,0,0});
    tbl.push_back(vec_t'{0, 1,0,'h40,0, 1,0,'h44,0, 0,0,0,0, 0,0, 0,1,'h40,0});
    tbl.push_back(vec_t'{0, 1,0,'h40,0, 1,0,'h44,0, 0,1,1,0, A0,0, 0,0,0,0});
    tbl.push_back(vec_t'{0, 1,0,'h40,0, 1,0,'h44,0, 0,0,0,0, A0,0, 0,1,'h44,0});
    tbl.push_back(vec_t'{0, 1,0,'h40,0, 1,0,'h44,0, 1,0,0,1, A0,B1, 0,0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,0, 0,0,0,0, 0,0,0,0, A0,B1, 0,1,'h40,0});
    tbl.push_back(vec_t'{0, 0,0,0,0, 0,0,0,0, 0,0,1,0, A0,B1, 0,0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,0, 0,0,0,0, 0,0,0,0, A0,B1, 0,0,0,0});
    // p1 streaming reads
    tbl.push_back(vec_t'{0, 0,0,0,0, 1,0,'h44,0, 0,1,0,0, A0,B1, 0,0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,0, 1,0,'h44,0, 0,0,0,0, A0,B1, 0,1,'h44,0});
    tbl.push_back(vec_t'{0, 0,0,0,0, 1,0,'h44,0, 0,1,0,1, A0,B1, 0,0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,0, 1,0,'h44,0, 0,0,0,0, A0,B1, 0,1,'h44,0});
    tbl.push_back(vec_t'{0, 0,0,0,0, 1,0,'h44,0, 0,1,0,1, A0,B1, 0,0,0,0});
    tbl.push_back(vec_t'{0, 0,0,0,0, 0,0,0,0, 0,0,0,0, A0,B1, 0,1,'h44,0});
    tbl.push_back(vec_t'{0, 0,0,0,0, 0,0,0,0, 0,0,0,1, A0,B1, 0,0,0,0});

    foreach (tbl[i]) run_row(i, tbl[i]);
    chk("mem[4]", mem[4], DB);

    // reset during the ACCESS cycle of a write
    @(negedge clk);
    p0_req = 1; p0_we = 1; p0_addr = 32'h20; p0_wdata = 32'hCAFEF00D;
    #1 chk("wr gnt0", 32'(p0_gnt), 1);
    @(negedge clk);
    p0_req = 0;
    #1 chk("wr mw", 32'(mem_write), 1);
    chk("wr ma", mem_addr, 32'h20);
    #1 rst_n = 0;
    p0_req = 1;
    #1 chk_zero("arst");
    @(negedge clk);
    #1 chk_zero("arst hold");
    chk("mem[8] hold", mem[8], 32'h55555555);
    p0_req = 0;
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk("post rv0", 32'(p0_rvalid), 0);
      chk("post rv1", 32'(p1_rvalid), 0);
      chk("post mw", 32'(mem_write), 0);
    end
    chk("mem[8]", mem[8], 32'h55555555);

    // last in-range word
    p0_read(32'hFC);
    #1 chk("fc mr", 32'(mem_read), 1);
    chk("fc err1", 32'(err), 0);
    @(negedge clk);
    #1 chk("fc rv0", 32'(p0_rvalid), 1);
    chk("fc rd0", p0_rdata, 32'h63636363);
    chk("fc err2", 32'(err), 0);

    // first out-of-range word
    p0_read(32'h100);
    #1 chk("oob err1", 32'(err), 0);
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    chk("oob mr", 32'(mem_read), 0);
    @(negedge clk);
    #1 chk("oob err2", 32'(err), 1);
    chk("oob rv0", 32'(p0_rvalid), 1);
    chk("oob rd0", p0_rdata, 0);
`else
    chk("oob mr", 32'(mem_read), 1);
    @(negedge clk);
    #1 chk("oob err2", 32'(err), 0);
    chk("oob rv0", 32'(p0_rvalid), 1);
    chk("oob rd0", p0_rdata, 32'h77777777);
`endif
    @(negedge clk);
    #1 chk("oob err3", 32'(err), 0);
    chk("oob rv0 off", 32'(p0_rvalid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64: number of 32-bit words in the attached data memory, used for bounds checking.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-004 SHALL have ports p0_req / p1_req  input  1: requester N has an access pending.
REQ-005 SHALL have ports p0_we / p1_we  input  1: 1 = write, 0 = read.
REQ-006 SHALL have ports p0_addr / p1_addr, p0_wdata / p1_wdata  input  32: byte address and write data.
REQ-007 SHALL have ports p0_gnt / p1_gnt  output  1: one-cycle pulse when the request is accepted.
REQ-008 SHALL have ports p0_rvalid / p1_rvalid  output  1, and p0_rdata / p1_rdata  output  32: read response.
REQ-009 SHALL have ports mem_write, mem_read  output  1, and mem_addr, mem_wdata  output  32: drive the data memory MemWrite, MemRead, addr and writeData.
REQ-010 SHALL have port mem_rdata  input  32: the memory's combinational readData.
REQ-011 SHALL have port err  output  1: out-of-range access pulse.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and ACCESS; IDLE goes to ACCESS when any req=1 and ACCESS always returns to IDLE; maximum throughput is one access per two cycles.
REQ-013 In IDLE with at least one req, SHALL pick a winner, pulse its gnt in that cycle (N), and register its we, addr and wdata.
REQ-014 Arbitration SHALL be round-robin:
- Single requester: that requester wins.
- Both requesting: the requester not served last wins.
- last_winner SHALL update only on a grant.
REQ-015 No gnt SHALL be issued in ACCESS; requests arriving then SHALL wait for IDLE.
REQ-016 In ACCESS (cycle N+1), mem_addr and mem_wdata SHALL carry the registered values.
- mem_write SHALL equal the registered we; mem_read SHALL equal its inverse.
- In IDLE, all mem_* outputs SHALL be 0.
REQ-017 For a read, SHALL capture mem_rdata at the end of N+1.
- SHALL pulse the winner's rvalid in N+2 with pN_rdata equal to the captured word.
- pN_rdata SHALL hold its value until the next read for that port.
REQ-018 Writes SHALL commit at the end of N+1 and SHALL produce no rvalid.
REQ-019 The requester SHALL hold req, we, addr and wdata stable until it sees gnt.
- A req=1 in the cycle after gnt is a new request.
REQ-020 An rvalid in N+2 SHALL coexist with a new gnt in the same cycle.
REQ-021 Word index SHALL be addr[9:2]; addr[1:0] SHALL be ignored.

Reset
REQ-022 rst_n=0 SHALL immediately, without waiting for a clock edge:
- force the FSM to IDLE;
- clear all gnt, rvalid, mem_*, err and pN_rdata outputs to 0;
- set last_winner to port 1, so port 0 wins the first tie.
REQ-023 A reset asserted in ACCESS SHALL abort the access.
- The write SHALL NOT commit after reset.
- A pending read SHALL produce no rvalid after rst_n rises.

Configuration
REQ-024 Macro DMEM_ARB_BOUNDS_CHECK_EN defined: an access with index >= MEM_WORDS SHALL still be granted, with the following behaviour.
- mem_write and mem_read SHALL stay 0 in its ACCESS cycle.
- err SHALL pulse in N+2.
- A read SHALL also pulse rvalid in N+2 with rdata = 0.
REQ-025 Macro undefined: err SHALL be tied 0 and all addresses SHALL pass through unchecked.

Verification
REQ-026 p0 write addr 0x10 data 0xDEADBEEF, then p0 read 0x10 -> gnt in cycle N; mem_write=1 in N+1; read rvalid in N+2 with rdata 0xDEADBEEF.
REQ-027 p0 and p1 both hold reads after reset -> p0 granted first, then p1 two cycles later, then p0 again; rvalid pulses alternate with matching data.
REQ-028 p1 reads continuously while p0 idle -> p1 granted every second cycle; no gnt ever lands in an ACCESS cycle.
REQ-029 rst_n pulsed low during the ACCESS of a write to 0x20 -> memory word 8 unchanged; no rvalid; all outputs 0 while reset is held.
REQ-030 Macro defined, p0 read at 0x100 (index 64) -> mem_read stays 0; err=1 and rvalid=1 with rdata 0 in N+2. Macro undefined, same stimulus -> err stays 0 and mem_read=1 in N+1.
